// File: rtl/rect_fill_engine_if.sv
// Bundles the command-decoder and SRAM-wrapper signals of rect_fill_engine.
// The slave modport is the engine. The master modport is the decoder and SRAM side.
interface rect_fill_engine_if #(
    parameter int ADDR_SIZE_BITS = 16,
    parameter int PIXEL_BITS     = 24,
    parameter int PIX_PER_LINE   = 64,
    parameter int COORD_BITS     = 12,
    parameter int LAYER_BITS     = 1
);
    logic                                 fill_en;
    logic                                 fill_type;
    logic [4*COORD_BITS-1:0]              coordinates;
    logic [PIXEL_BITS-1:0]                color_code;
    logic [PIXEL_BITS-1:0]                color_alt;
    logic [LAYER_BITS-1:0]                layer_num;
    logic                                 busy;
    logic                                 done;
    logic                                 read_enable;
    logic                                 write_enable;
    logic [ADDR_SIZE_BITS-1:0]            address;
    logic [PIXEL_BITS*PIX_PER_LINE-1:0]   write_data;
    logic [PIXEL_BITS*PIX_PER_LINE-1:0]   read_data;

    modport master (
        output fill_en, fill_type, coordinates, color_code, color_alt, layer_num, read_data,
        input  busy, done, read_enable, write_enable, address, write_data
    );

    modport slave (
        input  fill_en, fill_type, coordinates, color_code, color_alt, layer_num, read_data,
        output busy, done, read_enable, write_enable, address, write_data
    );
endinterface

// File: rtl/rect_fill_engine.sv
// Fills an inclusive rectangle of one layer with a solid or checker pattern, one SRAM line at a time.
// Fully covered lines are written blind. Edge lines are read, merged per pixel, then written back.
module rect_fill_engine #(
    parameter int ADDR_SIZE_BITS = 16,
    parameter int PIXEL_BITS     = 24,
    parameter int PIX_PER_LINE   = 64,
    parameter int COORD_BITS     = 12,
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int LAYER_BITS     = 1,
    parameter int CHECK_LOG2     = 3,
    parameter int READ_LATENCY   = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    rect_fill_engine_if.slave bus
);
    localparam int LINE_BITS    = PIXEL_BITS * PIX_PER_LINE;
    localparam int WPR          = SCREEN_W / PIX_PER_LINE;
    localparam int LAYER_STRIDE = WPR * SCREEN_H;
    localparam int WAIT_W       = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [COORD_BITS-1:0] PPL_C    = COORD_BITS'(PIX_PER_LINE);
    localparam logic [COORD_BITS-1:0] PPL_M1_C = COORD_BITS'(PIX_PER_LINE - 1);
    localparam logic [COORD_BITS-1:0] XLIM_C   = COORD_BITS'(SCREEN_W - 1);
    localparam logic [COORD_BITS-1:0] YLIM_C   = COORD_BITS'(SCREEN_H - 1);
    localparam logic [COORD_BITS-1:0] ONE_C    = COORD_BITS'(1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t                      r_state;
    logic                        r_type;
    logic [4*COORD_BITS-1:0]     r_coords;
    logic [PIXEL_BITS-1:0]       r_color;
    logic [PIXEL_BITS-1:0]       r_alt;
    logic [LAYER_BITS-1:0]       r_layer;
    logic [COORD_BITS-1:0]       r_xmin, r_xmax, r_ymax, r_y, r_chunk;
    logic [WAIT_W-1:0]           r_wait;
    logic                        r_busy, r_done, r_re, r_we;
    logic [ADDR_SIZE_BITS-1:0]   r_addr;
    logic [LINE_BITS-1:0]        r_wdata;

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.read_enable  = r_re;
    assign bus.write_enable = r_we;
    assign bus.address      = r_addr;
    assign bus.write_data   = r_wdata;

    logic [COORD_BITS-1:0] w_x1, w_y1, w_x2, w_y2;
    logic [COORD_BITS-1:0] w_lo_x, w_hi_x, w_lo_y, w_hi_y;
    logic [COORD_BITS-1:0] w_norm_xmin, w_norm_xmax, w_norm_ymin, w_norm_ymax;

    assign w_x1 = r_coords[4*COORD_BITS-1 -: COORD_BITS];
    assign w_y1 = r_coords[3*COORD_BITS-1 -: COORD_BITS];
    assign w_x2 = r_coords[2*COORD_BITS-1 -: COORD_BITS];
    assign w_y2 = r_coords[COORD_BITS-1:0];

    assign w_lo_x = (w_x1 < w_x2) ? w_x1 : w_x2;
    assign w_hi_x = (w_x1 < w_x2) ? w_x2 : w_x1;
    assign w_lo_y = (w_y1 < w_y2) ? w_y1 : w_y2;
    assign w_hi_y = (w_y1 < w_y2) ? w_y2 : w_y1;

    assign w_norm_xmin = (w_lo_x > XLIM_C) ? XLIM_C : w_lo_x;
    assign w_norm_xmax = (w_hi_x > XLIM_C) ? XLIM_C : w_hi_x;
    assign w_norm_ymin = (w_lo_y > YLIM_C) ? YLIM_C : w_lo_y;
    assign w_norm_ymax = (w_hi_y > YLIM_C) ? YLIM_C : w_hi_y;

    // Position of the chunk to be issued next: the first chunk out of SETUP, otherwise the one after r_chunk.
    logic [COORD_BITS-1:0] w_nx_xmin, w_nx_xmax, w_nx_y, w_nx_chunk;
    logic [COORD_BITS-1:0] w_first_chunk, w_last_chunk, w_nx_start, w_nx_end;
    logic                  w_nx_full, w_last;
    logic [ADDR_SIZE_BITS-1:0] w_nx_addr;

    assign w_first_chunk = r_xmin / PPL_C;
    assign w_last_chunk  = r_xmax / PPL_C;
    assign w_last        = (r_y == r_ymax) && (r_chunk == w_last_chunk);

    always_comb begin
        w_nx_xmin  = r_xmin;
        w_nx_xmax  = r_xmax;
        w_nx_y     = r_y;
        w_nx_chunk = r_chunk;
        if (r_state == S_SETUP) begin
            w_nx_xmin  = w_norm_xmin;
            w_nx_xmax  = w_norm_xmax;
            w_nx_y     = w_norm_ymin;
            w_nx_chunk = w_norm_xmin / PPL_C;
        end else if (r_chunk < w_last_chunk) begin
            w_nx_chunk = r_chunk + ONE_C;
        end else begin
            w_nx_chunk = w_first_chunk;
            w_nx_y     = r_y + ONE_C;
        end
    end

    assign w_nx_start = w_nx_chunk * PPL_C;
    assign w_nx_end   = w_nx_start + PPL_M1_C;
    assign w_nx_full  = (w_nx_start >= w_nx_xmin) && (w_nx_end <= w_nx_xmax);
    assign w_nx_addr  = ADDR_SIZE_BITS'(r_layer) * ADDR_SIZE_BITS'(LAYER_STRIDE)
                      + ADDR_SIZE_BITS'(w_nx_y) * ADDR_SIZE_BITS'(WPR)
                      + ADDR_SIZE_BITS'(w_nx_chunk);

    // The merge serves both the WAIT capture (current chunk) and blind writes (next chunk).
    logic [COORD_BITS-1:0] w_m_chunk, w_m_y, w_m_xmin, w_m_xmax;
    logic [LINE_BITS-1:0]  w_merge;

    assign w_m_chunk = (r_state == S_WAIT) ? r_chunk : w_nx_chunk;
    assign w_m_y     = (r_state == S_WAIT) ? r_y     : w_nx_y;
    assign w_m_xmin  = (r_state == S_WAIT) ? r_xmin  : w_nx_xmin;
    assign w_m_xmax  = (r_state == S_WAIT) ? r_xmax  : w_nx_xmax;

    generate
        for (genvar gi = 0; gi < PIX_PER_LINE; gi++) begin : g_pix
            logic [COORD_BITS-1:0] w_px;
            logic                  w_in;
            logic                  w_use_alt;
            assign w_px      = w_m_chunk * PPL_C + COORD_BITS'(gi);
            assign w_in      = (w_px >= w_m_xmin) && (w_px <= w_m_xmax);
            assign w_use_alt = r_type && (w_px[CHECK_LOG2] ^ w_m_y[CHECK_LOG2]);
            assign w_merge[gi*PIXEL_BITS +: PIXEL_BITS] =
                !w_in     ? bus.read_data[gi*PIXEL_BITS +: PIXEL_BITS] :
                w_use_alt ? r_alt : r_color;
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= S_IDLE;
            r_type   <= 1'b0;
            r_coords <= '0;
            r_color  <= '0;
            r_alt    <= '0;
            r_layer  <= '0;
            r_xmin   <= '0;
            r_xmax   <= '0;
            r_ymax   <= '0;
            r_y      <= '0;
            r_chunk  <= '0;
            r_wait   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_re     <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_done <= 1'b0;
            r_re   <= 1'b0;
            r_we   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.fill_en) begin
                        r_type   <= bus.fill_type;
                        r_coords <= bus.coordinates;
                        r_color  <= bus.color_code;
                        r_alt    <= bus.color_alt;
                        r_layer  <= bus.layer_num;
                        r_busy   <= 1'b1;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_xmin  <= w_norm_xmin;
                    r_xmax  <= w_norm_xmax;
                    r_ymax  <= w_norm_ymax;
                    r_y     <= w_nx_y;
                    r_chunk <= w_nx_chunk;
                    r_addr  <= w_nx_addr;
                    if (w_nx_full) begin
                        r_we    <= 1'b1;
                        r_wdata <= w_merge;
                        r_state <= S_WRITE;
                    end else begin
                        r_re    <= 1'b1;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_wait  <= WAIT_W'(READ_LATENCY - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == '0) begin
                        r_we    <= 1'b1;
                        r_wdata <= w_merge;
                        r_state <= S_WRITE;
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_y     <= w_nx_y;
                        r_chunk <= w_nx_chunk;
                        r_addr  <= w_nx_addr;
                        if (w_nx_full) begin
                            r_we    <= 1'b1;
                            r_wdata <= w_merge;
                            r_state <= S_WRITE;
                        end else begin
                            r_re    <= 1'b1;
                            r_state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: a one-cycle SRAM model returns a fixed background line,
// a negedge monitor logs strobes, and each task checks its own scenario against hand-computed values.
module tb_rect_fill_engine;
    localparam int AW = 16;
    localparam int PB = 24;
    localparam int PPL = 64;
    localparam int CB = 12;
    localparam int LW = PB * PPL;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    rect_fill_engine_if bus ();

    rect_fill_engine dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic [LW-1:0] bg_line = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.read_enable) bus.read_data <= bg_line;
    end

    logic [AW-1:0] wr_addr_q[$];
    logic [LW-1:0] wr_data_q[$];
    int            wr_cyc_q[$];
    int rd_cnt = 0, both_cnt = 0, done_cnt = 0, done_cyc = 0;
    int wr_base, rd_base, done_base;

    always @(negedge clk) begin
        if (bus.write_enable) begin
            wr_addr_q.push_back(bus.address);
            wr_data_q.push_back(bus.write_data);
            wr_cyc_q.push_back(cyc);
        end
        if (bus.read_enable) rd_cnt = rd_cnt + 1;
        if (bus.read_enable && bus.write_enable) both_cnt = both_cnt + 1;
        if (bus.done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    function automatic logic [LW-1:0] line_fill(int lo, int hi, logic [PB-1:0] c, logic [PB-1:0] b);
        logic [LW-1:0] l;
        for (int i = 0; i < PPL; i++) l[i*PB +: PB] = (i >= lo && i <= hi) ? c : b;
        return l;
    endfunction

    function automatic logic [LW-1:0] checker_line(logic [PB-1:0] even_c, logic [PB-1:0] odd_c);
        logic [LW-1:0] l;
        for (int i = 0; i < PPL; i++) l[i*PB +: PB] = ((i / 8) % 2 == 1) ? odd_c : even_c;
        return l;
    endfunction

    function automatic int first_diff(logic [LW-1:0] a, logic [LW-1:0] b);
        for (int i = 0; i < PPL; i++) if (a[i*PB +: PB] !== b[i*PB +: PB]) return i;
        return 0;
    endfunction

    task automatic start_fill(input int x1, input int y1, input int x2, input int y2, input logic typ,
                              input logic [PB-1:0] c, input logic [PB-1:0] alt, input logic lay);
        @(posedge clk);
        #1;
        bus.coordinates = {CB'(x1), CB'(y1), CB'(x2), CB'(y2)};
        bus.fill_type   = typ;
        bus.color_code  = c;
        bus.color_alt   = alt;
        bus.layer_num   = lay;
        bus.fill_en     = 1'b1;
        start_cyc = cyc;
        wr_base   = wr_addr_q.size();
        rd_base   = rd_cnt;
        done_base = done_cnt;
        @(posedge clk);
        #1;
        bus.fill_en = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == done_base && n < 200) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (done_cnt == done_base) begin
            $display("FAIL %s_timeout got=no_done exp=done within 200 cycles", name);
            bad++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin $display("FAIL rst_busy got=%b exp=0", bus.busy); bad++; end
        total++; if (bus.done !== 1'b0) begin $display("FAIL rst_done got=%b exp=0", bus.done); bad++; end
        total++; if (bus.read_enable !== 1'b0) begin $display("FAIL rst_re got=%b exp=0", bus.read_enable); bad++; end
        total++; if (bus.write_enable !== 1'b0) begin $display("FAIL rst_we got=%b exp=0", bus.write_enable); bad++; end
        total++; if (bus.address !== '0) begin $display("FAIL rst_addr got=%0d exp=0", bus.address); bad++; end
        total++; if (bus.write_data !== '0) begin $display("FAIL rst_wdata got=nonzero exp=0"); bad++; end
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        $display("test_reset: outputs checked during reset");
    endtask

    task automatic test_full_line();
        logic [LW-1:0] exp = line_fill(0, 63, 24'hFF0000, 24'h000000);
        int nw;
        start_fill(0, 0, 63, 0, 1'b0, 24'hFF0000, 24'h0, 1'b0);
        wait_done("s1");
        nw = wr_addr_q.size() - wr_base;
        total++; if (nw !== 1) begin $display("FAIL s1_wr_count got=%0d exp=1", nw); bad++; end
        if (nw >= 1) begin
            total++; if (wr_addr_q[wr_base] !== 16'd0) begin $display("FAIL s1_addr got=%0d exp=0", wr_addr_q[wr_base]); bad++; end
            total++; if (wr_data_q[wr_base] !== exp) begin $display("FAIL s1_data pixel=%0d got=%h exp=%h", first_diff(wr_data_q[wr_base], exp), wr_data_q[wr_base][first_diff(wr_data_q[wr_base], exp)*PB +: PB], exp[first_diff(wr_data_q[wr_base], exp)*PB +: PB]); bad++; end
            total++; if (wr_cyc_q[wr_base] - start_cyc !== 2) begin $display("FAIL s1_wr_cycle got=%0d exp=2", wr_cyc_q[wr_base] - start_cyc); bad++; end
        end
        total++; if (rd_cnt - rd_base !== 0) begin $display("FAIL s1_reads got=%0d exp=0", rd_cnt - rd_base); bad++; end
        total++; if (done_cyc - start_cyc !== 3) begin $display("FAIL s1_done_cycle got=%0d exp=3", done_cyc - start_cyc); bad++; end
        total++; if (bus.busy !== 1'b0) begin $display("FAIL s1_busy_after got=%b exp=0", bus.busy); bad++; end
        $display("test_full_line: %0d write(s), done at cycle %0d", nw, done_cyc - start_cyc);
    endtask

    task automatic test_partial_span(input bit swapped);
        logic [LW-1:0] e0 = line_fill(10, 63, 24'h00FF00, 24'h123456);
        logic [LW-1:0] e1 = line_fill(0, 6, 24'h00FF00, 24'h123456);
        string nm = swapped ? "s3" : "s2";
        int nw;
        bg_line = line_fill(0, 63, 24'h123456, 24'h123456);
        if (swapped) start_fill(70, 2, 10, 2, 1'b0, 24'h00FF00, 24'h0, 1'b0);
        else         start_fill(10, 2, 70, 2, 1'b0, 24'h00FF00, 24'h0, 1'b0);
        wait_done(nm);
        nw = wr_addr_q.size() - wr_base;
        total++; if (nw !== 2) begin $display("FAIL %s_wr_count got=%0d exp=2", nm, nw); bad++; end
        if (nw >= 2) begin
            total++; if (wr_addr_q[wr_base] !== 16'd20) begin $display("FAIL %s_addr0 got=%0d exp=20", nm, wr_addr_q[wr_base]); bad++; end
            total++; if (wr_data_q[wr_base] !== e0) begin $display("FAIL %s_data0 pixel=%0d got=%h exp=%h", nm, first_diff(wr_data_q[wr_base], e0), wr_data_q[wr_base][first_diff(wr_data_q[wr_base], e0)*PB +: PB], e0[first_diff(wr_data_q[wr_base], e0)*PB +: PB]); bad++; end
            total++; if (wr_cyc_q[wr_base] - start_cyc !== 4) begin $display("FAIL %s_wr0_cycle got=%0d exp=4", nm, wr_cyc_q[wr_base] - start_cyc); bad++; end
            total++; if (wr_addr_q[wr_base+1] !== 16'd21) begin $display("FAIL %s_addr1 got=%0d exp=21", nm, wr_addr_q[wr_base+1]); bad++; end
            total++; if (wr_data_q[wr_base+1] !== e1) begin $display("FAIL %s_data1 pixel=%0d got=%h exp=%h", nm, first_diff(wr_data_q[wr_base+1], e1), wr_data_q[wr_base+1][first_diff(wr_data_q[wr_base+1], e1)*PB +: PB], e1[first_diff(wr_data_q[wr_base+1], e1)*PB +: PB]); bad++; end
            total++; if (wr_cyc_q[wr_base+1] - start_cyc !== 7) begin $display("FAIL %s_wr1_cycle got=%0d exp=7", nm, wr_cyc_q[wr_base+1] - start_cyc); bad++; end
        end
        total++; if (rd_cnt - rd_base !== 2) begin $display("FAIL %s_reads got=%0d exp=2", nm, rd_cnt - rd_base); bad++; end
        total++; if (done_cyc - start_cyc !== 8) begin $display("FAIL %s_done_cycle got=%0d exp=8", nm, done_cyc - start_cyc); bad++; end
        $display("test_partial_span(%s): %0d writes, done at cycle %0d", nm, nw, done_cyc - start_cyc);
    endtask

    task automatic test_clamp_layer();
        logic [LW-1:0] exp = line_fill(24, 63, 24'h0000FF, 24'hABCDEF);
        int nw;
        bg_line = line_fill(0, 63, 24'hABCDEF, 24'hABCDEF);
        start_fill(600, 479, 1000, 900, 1'b0, 24'h0000FF, 24'h0, 1'b1);
        wait_done("s4");
        nw = wr_addr_q.size() - wr_base;
        total++; if (nw !== 1) begin $display("FAIL s4_wr_count got=%0d exp=1", nw); bad++; end
        if (nw >= 1) begin
            total++; if (wr_addr_q[wr_base] !== 16'd9599) begin $display("FAIL s4_addr got=%0d exp=9599", wr_addr_q[wr_base]); bad++; end
            total++; if (wr_data_q[wr_base] !== exp) begin $display("FAIL s4_data pixel=%0d got=%h exp=%h", first_diff(wr_data_q[wr_base], exp), wr_data_q[wr_base][first_diff(wr_data_q[wr_base], exp)*PB +: PB], exp[first_diff(wr_data_q[wr_base], exp)*PB +: PB]); bad++; end
        end
        total++; if (rd_cnt - rd_base !== 1) begin $display("FAIL s4_reads got=%0d exp=1", rd_cnt - rd_base); bad++; end
        total++; if (done_cyc - start_cyc !== 5) begin $display("FAIL s4_done_cycle got=%0d exp=5", done_cyc - start_cyc); bad++; end
        $display("test_clamp_layer: %0d write(s), done at cycle %0d", nw, done_cyc - start_cyc);
    endtask

    task automatic test_checker();
        logic [LW-1:0] ep = checker_line(24'h000000, 24'hFFFFFF);
        logic [LW-1:0] ei = checker_line(24'hFFFFFF, 24'h000000);
        int nw;
        bg_line = line_fill(0, 63, 24'h555555, 24'h555555);
        start_fill(0, 0, 63, 1, 1'b1, 24'h000000, 24'hFFFFFF, 1'b0);
        wait_done("s5");
        nw = wr_addr_q.size() - wr_base;
        total++; if (nw !== 2) begin $display("FAIL s5_wr_count got=%0d exp=2", nw); bad++; end
        if (nw >= 2) begin
            total++; if (wr_addr_q[wr_base] !== 16'd0) begin $display("FAIL s5_addr0 got=%0d exp=0", wr_addr_q[wr_base]); bad++; end
            total++; if (wr_data_q[wr_base] !== ep) begin $display("FAIL s5_data0 pixel=%0d got=%h exp=%h", first_diff(wr_data_q[wr_base], ep), wr_data_q[wr_base][first_diff(wr_data_q[wr_base], ep)*PB +: PB], ep[first_diff(wr_data_q[wr_base], ep)*PB +: PB]); bad++; end
            total++; if (wr_addr_q[wr_base+1] !== 16'd10) begin $display("FAIL s5_addr1 got=%0d exp=10", wr_addr_q[wr_base+1]); bad++; end
            total++; if (wr_data_q[wr_base+1] !== ep) begin $display("FAIL s5_data1 pixel=%0d got=%h exp=%h", first_diff(wr_data_q[wr_base+1], ep), wr_data_q[wr_base+1][first_diff(wr_data_q[wr_base+1], ep)*PB +: PB], ep[first_diff(wr_data_q[wr_base+1], ep)*PB +: PB]); bad++; end
        end
        total++; if (rd_cnt - rd_base !== 0) begin $display("FAIL s5_reads got=%0d exp=0", rd_cnt - rd_base); bad++; end
        total++; if (done_cyc - start_cyc !== 4) begin $display("FAIL s5_done_cycle got=%0d exp=4", done_cyc - start_cyc); bad++; end
        // Row 8 has y bit 3 set, so the pattern phase flips.
        start_fill(0, 8, 63, 8, 1'b1, 24'h000000, 24'hFFFFFF, 1'b0);
        wait_done("s5b");
        nw = wr_addr_q.size() - wr_base;
        total++; if (nw !== 1) begin $display("FAIL s5b_wr_count got=%0d exp=1", nw); bad++; end
        if (nw >= 1) begin
            total++; if (wr_addr_q[wr_base] !== 16'd80) begin $display("FAIL s5b_addr got=%0d exp=80", wr_addr_q[wr_base]); bad++; end
            total++; if (wr_data_q[wr_base] !== ei) begin $display("FAIL s5b_data pixel=%0d got=%h exp=%h", first_diff(wr_data_q[wr_base], ei), wr_data_q[wr_base][first_diff(wr_data_q[wr_base], ei)*PB +: PB], ei[first_diff(wr_data_q[wr_base], ei)*PB +: PB]); bad++; end
        end
        $display("test_checker: rows 0,1,8 checked");
    endtask

    task automatic test_single_pixel();
        logic [LW-1:0] exp = line_fill(5, 5, 24'hC0FFEE, 24'h010203);
        int nw;
        bg_line = line_fill(0, 63, 24'h010203, 24'h010203);
        start_fill(5, 5, 5, 5, 1'b0, 24'hC0FFEE, 24'h0, 1'b0);
        wait_done("px");
        nw = wr_addr_q.size() - wr_base;
        total++; if (nw !== 1) begin $display("FAIL px_wr_count got=%0d exp=1", nw); bad++; end
        if (nw >= 1) begin
            total++; if (wr_addr_q[wr_base] !== 16'd50) begin $display("FAIL px_addr got=%0d exp=50", wr_addr_q[wr_base]); bad++; end
            total++; if (wr_data_q[wr_base] !== exp) begin $display("FAIL px_data pixel=%0d got=%h exp=%h", first_diff(wr_data_q[wr_base], exp), wr_data_q[wr_base][first_diff(wr_data_q[wr_base], exp)*PB +: PB], exp[first_diff(wr_data_q[wr_base], exp)*PB +: PB]); bad++; end
        end
        total++; if (rd_cnt - rd_base !== 1) begin $display("FAIL px_reads got=%0d exp=1", rd_cnt - rd_base); bad++; end
        total++; if (done_cyc - start_cyc !== 5) begin $display("FAIL px_done_cycle got=%0d exp=5", done_cyc - start_cyc); bad++; end
        $display("test_single_pixel: %0d write(s), done at cycle %0d", nw, done_cyc - start_cyc);
    endtask

    task automatic test_reset_abort();
        int nw;
        bg_line = line_fill(0, 63, 24'h123456, 24'h123456);
        start_fill(10, 2, 70, 2, 1'b0, 24'h00FF00, 24'h0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin $display("FAIL ab_busy got=%b exp=0", bus.busy); bad++; end
        total++; if (bus.read_enable !== 1'b0 || bus.write_enable !== 1'b0) begin $display("FAIL ab_strobes got=%b%b exp=00", bus.read_enable, bus.write_enable); bad++; end
        total++; if (bus.address !== '0) begin $display("FAIL ab_addr got=%0d exp=0", bus.address); bad++; end
        total++; if (bus.write_data !== '0 || bus.done !== 1'b0) begin $display("FAIL ab_wdata_done got=nonzero exp=0"); bad++; end
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        nw = wr_addr_q.size() - wr_base;
        total++; if (nw !== 0) begin $display("FAIL ab_no_write got=%0d exp=0", nw); bad++; end
        total++; if (done_cnt !== done_base) begin $display("FAIL ab_no_done got=%0d exp=0", done_cnt - done_base); bad++; end
        $display("test_reset_abort: aborted fill left %0d writes", nw);
        test_full_line();
    endtask

    task automatic test_busy_ignore();
        logic [LW-1:0] e0 = line_fill(10, 63, 24'h00FF00, 24'h123456);
        int nw;
        bg_line = line_fill(0, 63, 24'h123456, 24'h123456);
        start_fill(10, 2, 70, 2, 1'b0, 24'h00FF00, 24'h0, 1'b0);
        bus.coordinates = {CB'(0), CB'(0), CB'(63), CB'(0)};
        bus.color_code  = 24'hFF00FF;
        bus.fill_en     = 1'b1;
        @(posedge clk);
        #1;
        bus.fill_en = 1'b0;
        wait_done("bi");
        repeat (5) @(posedge clk);
        #1;
        nw = wr_addr_q.size() - wr_base;
        total++; if (nw !== 2) begin $display("FAIL bi_wr_count got=%0d exp=2", nw); bad++; end
        if (nw >= 2) begin
            total++; if (wr_addr_q[wr_base] !== 16'd20 || wr_addr_q[wr_base+1] !== 16'd21) begin $display("FAIL bi_addrs got=%0d,%0d exp=20,21", wr_addr_q[wr_base], wr_addr_q[wr_base+1]); bad++; end
            total++; if (wr_data_q[wr_base] !== e0) begin $display("FAIL bi_data0 pixel=%0d got=%h exp=%h", first_diff(wr_data_q[wr_base], e0), wr_data_q[wr_base][first_diff(wr_data_q[wr_base], e0)*PB +: PB], e0[first_diff(wr_data_q[wr_base], e0)*PB +: PB]); bad++; end
        end
        total++; if (done_cyc - start_cyc !== 8) begin $display("FAIL bi_done_cycle got=%0d exp=8", done_cyc - start_cyc); bad++; end
        total++; if (bus.busy !== 1'b0) begin $display("FAIL bi_busy_after got=%b exp=0", bus.busy); bad++; end
        total++; if (both_cnt !== 0) begin $display("FAIL both_strobes got=%0d exp=0", both_cnt); bad++; end
        $display("test_busy_ignore: %0d writes, done at cycle %0d", nw, done_cyc - start_cyc);
    endtask

    initial begin
        bus.fill_en     = 1'b0;
        bus.fill_type   = 1'b0;
        bus.coordinates = '0;
        bus.color_code  = '0;
        bus.color_alt   = '0;
        bus.layer_num   = '0;
        bus.read_data   = '0;
        test_reset();
        test_full_line();
        test_partial_span(1'b0);
        test_partial_span(1'b1);
        test_clamp_layer();
        test_checker();
        test_single_pixel();
        test_reset_abort();
        test_busy_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=still running exp=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
- Parametrised successor to the single-type fill path: fills an axis-aligned rectangle of a selected layer in on-chip SRAM with either a solid colour or a two-colour checker pattern.
- Operates on whole SRAM lines of PIX_PER_LINE pixels. Fully covered lines are written directly. Partially covered edge lines use read-modify-write.
- Sits between the top-level command decoder and the on-chip SRAM wrapper, replacing the separate fill controller and datapath.

Parameters:
- ADDR_SIZE_BITS, 16, SRAM address width
- PIXEL_BITS, 24, bits per pixel (RGB888)
- PIX_PER_LINE, 64, pixels per SRAM line; line width = PIXEL_BITS*PIX_PER_LINE
- COORD_BITS, 12, width of each coordinate field
- SCREEN_W, 640, screen width in pixels; must be a multiple of PIX_PER_LINE
- SCREEN_H, 480, screen height in pixels
- LAYER_BITS, 1, layer select width
- CHECK_LOG2, 3, checker square edge = 2^CHECK_LOG2 pixels
- READ_LATENCY, 1, cycles from read_enable to valid read_data (>=1)

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- fill_en  in  1  start pulse; sampled only in IDLE
- fill_type  in  1  0 = solid, 1 = checker
- coordinates  in  4*COORD_BITS  {x1,y1,x2,y2}, x1 in MSBs
- color_code  in  PIXEL_BITS  primary colour
- color_alt  in  PIXEL_BITS  secondary checker colour
- layer_num  in  LAYER_BITS  target layer
- busy  out  1  high from SETUP through DONE
- done  out  1  one-cycle completion pulse
- read_enable  out  1  SRAM read strobe
- write_enable  out  1  SRAM write strobe
- address  out  ADDR_SIZE_BITS  SRAM line address
- write_data  out  PIXEL_BITS*PIX_PER_LINE  line to write
- read_data  in  PIXEL_BITS*PIX_PER_LINE  line read from SRAM

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal registers cleared. Reset asserted mid-fill aborts immediately. No done pulse is produced. The SRAM line in flight may be left unwritten.
- Command latching: all command inputs are latched on the cycle fill_en is sampled in IDLE. fill_en while busy is ignored.
- Setup normalisation: xmin = min(x1,x2), xmax = max(x1,x2); same for y. Each value is then clamped to SCREEN_W-1 or SCREEN_H-1. The rectangle is inclusive on all edges.
- Line geometry: WPR = SCREEN_W/PIX_PER_LINE and LAYER_STRIDE = WPR*SCREEN_H.
- Address: address = layer*LAYER_STRIDE + y*WPR + chunk, where chunk = x/PIX_PER_LINE.
- Pixel packing: pixel i of a line is at bits [i*PIXEL_BITS +: PIXEL_BITS] and represents x = chunk*PIX_PER_LINE + i.
- Colour: solid mode uses color_code. Checker mode uses color_code when bit CHECK_LOG2 of (x XOR y) is 0, otherwise color_alt.
- Per-pixel merge: pixels with xmin <= x <= xmax take the fill colour. All other pixels take the corresponding read_data pixel.
- FSM states: IDLE, SETUP, READ, WAIT, WRITE, DONE.
  - IDLE -> SETUP on fill_en.
  - SETUP (1 cycle): normalise and clamp; y = ymin, chunk = xmin/PIX_PER_LINE.
  - From SETUP or after WRITE, the next chunk goes to WRITE if fully covered (chunk start >= xmin and chunk end <= xmax), otherwise to READ.
  - READ (1 cycle): read_enable = 1, address valid.
  - WAIT (READ_LATENCY cycles): read_data is captured on the last WAIT cycle.
  - WRITE (1 cycle): write_enable = 1 with address and merged write_data. Then advance: chunk++ if chunk < xmax/PIX_PER_LINE; otherwise chunk resets to xmin/PIX_PER_LINE and y++. After y = ymax and the last chunk, go to DONE.
  - DONE (1 cycle): done = 1; -> IDLE.
- Strobe rules: read_enable and write_enable are never high together. address is held stable during READ/WAIT/WRITE.
- Cycle cost per row chunk: full = 1 cycle, partial = 2+READ_LATENCY cycles.
- Total latency: SETUP + sum of chunk costs + DONE.
- A degenerate 1x1 rectangle is a single partial chunk.

Test Plan:
1. Reset, then solid fill (0,0)-(63,0), colour 0xFF0000, layer 0, fill_en at cycle 0 -> cycle 2: write_enable=1, address=0, all 64 pixels 0xFF0000, read_enable never high; done=1 at cycle 3.
2. Solid fill (10,2)-(70,2), colour 0x00FF00, SRAM preloaded 0x123456 -> read/write at address 20 (pixels 10..63 green, 0..9 keep 0x123456), then address 21 (pixels 0..6 green, rest keep 0x123456); done at cycle 8.
3. Swapped coordinates (70,2)-(10,2) -> identical SRAM writes and timing to scenario 2.
4. Clamp and layer: (600,479)-(1000,900), layer 1 -> single partial chunk at address 4800+479*10+9=9599; pixels 24..63 filled, 0..23 preserved.
5. Checker fill (0,0)-(63,1), color_code 0x000000, color_alt 0xFFFFFF -> address 0: pixels 0..7 black, 8..15 white, alternating; address 10 has the same pattern (y bit 3 = 0).
6. Assert n_rst low during WAIT of scenario 2 -> all outputs 0 next edge, no done; fill_en after release starts cleanly; fill_en pulsed while busy -> ignored.
